rng_share_arbiter: RTL and testbench
====================================

RNG_SHARE_ARBITER -- requirements
Module: rng_share_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters sharing the generator (2..16).
REQ-002 SHALL have parameter SEED, default 64'hFEEDBABEDEADBEEF, meaning the LFSR reset value; it must be nonzero.
REQ-003 SHALL have port CLK  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  N_REQ  level request per requester, held until granted.
REQ-006 SHALL have port gnt  output  N_REQ  registered one-hot grant, one-cycle pulse.
REQ-007 SHALL have port rnd  output  64  registered random word, valid only while rnd_valid=1.
REQ-008 SHALL have port rnd_valid  output  1  registered, high exactly when gnt is nonzero.

Function
REQ-009 SHALL hold a 64-bit Fibonacci LFSR: feedback = bit63^bit62^bit60^bit59; shift left; feedback enters bit0.
REQ-010 SHALL implement FSM {FILL, READY}.
- FILL: LFSR steps once per cycle; 6-bit fill counter increments.
- READY: LFSR and counter frozen.
REQ-011 SHALL move FILL->READY on the edge that performs the 64th step since entering FILL.
- Every dispensed word therefore contains 64 bits not previously dispensed.
REQ-012 SHALL, in READY with req!=0, grant one requester at the next edge.
- gnt=one-hot(winner), rnd=LFSR contents, rnd_valid=1.
- Counter cleared; state->FILL.
REQ-013 SHALL select the winner by round-robin: first asserted req at index >= ptr, wrapping N_REQ-1->0; ptr<=winner+1 mod N_REQ on each grant.
REQ-014 SHALL stay in READY with gnt=0 and rnd_valid=0 while req==0; the word is held indefinitely without stepping.
REQ-015 SHALL ignore a req deasserted before its grant; no state is kept per requester.
REQ-016 SHALL drive gnt=0 and rnd_valid=0 on every cycle except the single grant cycle; rnd holds its last value otherwise.
REQ-017 SHALL give a sustained-request throughput of one word per 65 cycles: 64 fill cycles plus 1 grant edge.

Reset
REQ-018 SHALL, when nRST=0 at an edge, set:
- LFSR=SEED, counter=0, ptr=0, state=FILL.
- gnt=0, rnd=64'd0, rnd_valid=0.
REQ-019 SHALL let reset mid-fill or mid-grant override all activity; any pending grant is discarded.
REQ-020 SHALL reach READY on the 64th edge after nRST rises; with req held, the first gnt appears on the 65th edge.

Configuration
REQ-021 SHALL, with macro RNG_RESEED_EN defined, add ports seed_ld (input, 1) and seed_in (input, 64).
- seed_ld=1 at an edge loads LFSR=seed_in, or SEED if seed_in==0.
- The same edge sets counter=0 and state=FILL.
- seed_ld takes priority over a grant on the same edge (no gnt issued) and never alters ptr.
REQ-022 SHALL, without RNG_RESEED_EN, omit seed_ld and seed_in; the LFSR is seeded only by reset.

Structure
REQ-023 SHALL place in package rng_pkg:
- LFSR_W=64, FILL_LEN=64, the tap indices 63/62/60/59.
- The FSM state typedef rng_state_t.
REQ-024 SHALL factor the LFSR into sub-module rng_lfsr_core.
- Ports: step, load, load_val, q.
- The arbiter FSM and round-robin logic stay in rng_share_arbiter.

Verification
REQ-025 SHALL cover reset release with req=4'b0001 held -> gnt=4'b0001 and rnd_valid=1 on edge 65 only; rnd equals a bit-accurate model after 64 steps from SEED.
REQ-026 SHALL cover req=4'b1111 held continuously -> grants 0001, 0010, 0100, 1000, 0001 on edges 65, 130, 195, 260, 325; each rnd matches the model.
REQ-027 SHALL cover reaching READY with req=0, idling 100 cycles, then req=4'b0100 -> gnt=4'b0100 one edge later; rnd equals the word available at READY entry (no stepping while idle).
REQ-028 SHALL cover nRST=0 pulsed for 1 cycle at fill count 30 -> gnt and rnd_valid stay 0; next grant 65 edges after nRST rises; rnd equals the first post-reset word.
REQ-029 SHALL cover, with RNG_RESEED_EN, seed_ld=1 with seed_in=0 on the same edge as a pending grant -> no gnt; LFSR=SEED; next grant 65 edges later with the REQ-025 word.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared constants, FSM state type and LFSR step function for the shared RNG arbiter.
// The 64-bit Fibonacci LFSR taps bits 63/62/60/59, shifts left, and feeds back into bit 0.
package rng_pkg;

    localparam int LFSR_W   = 64;
    localparam int FILL_LEN = 64;
    localparam int CNT_W    = $clog2(FILL_LEN);

    localparam int TAP_A = 63;
    localparam int TAP_B = 62;
    localparam int TAP_C = 60;
    localparam int TAP_D = 59;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } rng_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        logic fb;
        fb = cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D];
        return {cur[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/rng_lfsr_core.sv
// 64-bit Fibonacci LFSR register. A load has priority over a step; with neither, the value holds.
module rng_lfsr_core
    import rng_pkg::*;
(
    input  logic              CLK,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge CLK) begin
        if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/rng_share_arbiter.sv
// Round-robin sharing of one 64-bit LFSR among N_REQ requesters; every word dispensed is 64 fresh bits.
// Optional RNG_RESEED_EN adds seed_ld/seed_in for runtime reseeding. SEED must be nonzero.
module rng_share_arbiter
    import rng_pkg::*;
#(
    parameter int          N_REQ = 4,
    parameter logic [63:0] SEED  = 64'hFEEDBABEDEADBEEF
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [LFSR_W-1:0] rnd,
    output logic              rnd_valid
`ifdef RNG_RESEED_EN
    ,
    input  logic              seed_ld,
    input  logic [LFSR_W-1:0] seed_in
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    rng_state_t        state;
    logic [CNT_W-1:0]  fill_cnt;
    logic [PTR_W-1:0]  ptr;

    logic              reseed;
    logic [LFSR_W-1:0] reseed_val;
    logic              lfsr_step;
    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_load_val;
    logic [LFSR_W-1:0] lfsr_q;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  cand;
    logic [PTR_W-1:0]  ptr_after;
    logic [N_REQ-1:0]  gnt_onehot;

`ifdef RNG_RESEED_EN
    // An all-zero seed would lock the LFSR, so it falls back to SEED.
    assign reseed     = seed_ld;
    assign reseed_val = (seed_in == '0) ? SEED : seed_in;
`else
    assign reseed     = 1'b0;
    assign reseed_val = SEED;
`endif

    assign lfsr_load     = !nRST || reseed;
    assign lfsr_load_val = !nRST ? SEED : reseed_val;
    assign lfsr_step     = (state == FILL) && !reseed;

    rng_lfsr_core u_lfsr (
        .CLK      (CLK),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .q        (lfsr_q)
    );

    // Round-robin search: first asserted request at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_onehot          = '0;
        gnt_onehot[win_idx] = 1'b1;
        ptr_after           = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= FILL;
            fill_cnt  <= '0;
            ptr       <= '0;
            gnt       <= '0;
            rnd       <= '0;
            rnd_valid <= 1'b0;
        end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            if (reseed) begin
                state    <= FILL;
                fill_cnt <= '0;
            end else begin
                case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == CNT_W'(FILL_LEN - 1)) begin
                            state <= READY;
                        end
                    end
                    READY: begin
                        if (win_found) begin
                            gnt       <= gnt_onehot;
                            rnd       <= lfsr_q;
                            rnd_valid <= 1'b1;
                            fill_cnt  <= '0;
                            ptr       <= ptr_after;
                            state     <= FILL;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Scoreboard bench for rng_share_arbiter: a step-count model predicts each grant; a monitor checks outputs.
// Define RNG_RESEED_EN to also exercise the runtime reseed ports.
module tb_rng_share_arbiter;

    localparam int          N    = 4;
    localparam logic [63:0] SEED = 64'hFEEDBABEDEADBEEF;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [63:0]   rnd;
    logic          rnd_valid;
    logic          seed_ld;
    logic [63:0]   seed_in;

    rng_share_arbiter #(.N_REQ(N), .SEED(SEED)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req       (req),
        .gnt       (gnt),
        .rnd       (rnd),
        .rnd_valid (rnd_valid)
`ifdef RNG_RESEED_EN
        ,
        .seed_ld   (seed_ld),
        .seed_in   (seed_in)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic [N-1:0] g;
        logic [63:0] w;
    } exp_t;

    exp_t sbq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, want);
    endtask

    function automatic logic [63:0] lfsr_adv(input logic [63:0] x, input int n);
        logic [63:0] v;
        logic        fb;
        v = x;
        for (int i = 0; i < n; i++) begin
            fb = v[63] ^ v[62] ^ v[60] ^ v[59];
            v  = {v[62:0], fb};
        end
        return v;
    endfunction

    // Reference model: the word is fresh once 64 steps have been taken since the last refill.
    logic [63:0] m_word;
    int          m_steps;
    int          m_ptr;
    int          ecount = 0;

    task automatic model_edge();
        int  w;
        bit  found;
        exp_t e;
        if (!nRST) begin
            m_word  = SEED;
            m_steps = 0;
            m_ptr   = 0;
        end else if (seed_ld) begin
            m_word  = (seed_in == 64'd0) ? SEED : seed_in;
            m_steps = 0;
        end else if (m_steps < 64) begin
            m_word  = lfsr_adv(m_word, 1);
            m_steps = m_steps + 1;
        end else if (req != '0) begin
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    w     = (m_ptr + k) % N;
                end
            end
            e.cyc = ecount;
            e.g   = N'(1) << w;
            e.w   = m_word;
            sbq.push_back(e);
            m_ptr   = (w + 1) % N;
            m_steps = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        ecount++;
        model_edge();
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Monitor
    int          mcyc = 0;
    bit          done = 1'b0;
    int          last_gcyc = -1;
    logic [63:0] last_rnd = 64'd0;
    logic [63:0] held = 64'd0;

    initial begin : monitor
        bit   rst_e;
        exp_t e;
        forever begin
            @(posedge CLK);
            mcyc++;
            rst_e = !nRST;
            @(negedge CLK);
            if (done) break;
            if (rst_e) held = 64'd0;
            if (gnt != '0 || rnd_valid) begin
                last_gcyc = mcyc;
                last_rnd  = rnd;
                if (sbq.size() == 0) begin
                    chk("unexpected_grant", 64'({rnd_valid, gnt}), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("grant_cycle", 64'(mcyc), 64'(e.cyc));
                    chk("gnt", 64'(gnt), 64'(e.g));
                    chk("rnd", rnd, e.w);
                    chk("rnd_valid", 64'(rnd_valid), 64'd1);
                    held = e.w;
                end
            end else begin
                chk("rnd_hold", rnd, held);
            end
        end
    end

    initial begin : stimulus
        int rel;
        logic [63:0] first_word;
        first_word = lfsr_adv(SEED, 64);
        nRST    = 1'b0;
        req     = '0;
        seed_ld = 1'b0;
        seed_in = 64'd0;
        ticks(3);
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_rnd_valid", 64'(rnd_valid), 64'd0);
        chk("reset_rnd", rnd, 64'd0);

        // Single requester held from reset release
        req  = 4'b0001;
        nRST = 1'b1;
        rel  = ecount;
        ticks(70);
        chk("first_grant_edge", 64'(last_gcyc - rel), 64'd65);
        chk("first_word", last_rnd, first_word);

        // All requesters held: rotation 0,1,2,3,0
        req  = '0;
        nRST = 1'b0;
        tick();
        req  = 4'b1111;
        nRST = 1'b1;
        rel  = ecount;
        ticks(330);
        chk("fifth_grant_edge", 64'(last_gcyc - rel), 64'd325);

        // Idle in READY for 100 cycles, then a single request
        req  = '0;
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        ticks(164);
        req = 4'b0100;
        rel = ecount;
        tick();
        req = '0;
        ticks(3);
        chk("idle_grant_edge", 64'(last_gcyc - rel), 64'd1);
        chk("idle_word", last_rnd, first_word);

        // Reset pulse mid-fill at count 30
        nRST = 1'b0;
        tick();
        req  = 4'b0001;
        nRST = 1'b1;
        ticks(30);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        rel  = ecount;
        ticks(66);
        chk("post_reset_grant_edge", 64'(last_gcyc - rel), 64'd65);
        chk("post_reset_word", last_rnd, first_word);

`ifdef RNG_RESEED_EN
        // Zero reseed collides with a pending grant
        req  = '0;
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        ticks(64);
        req     = 4'b0001;
        seed_ld = 1'b1;
        seed_in = 64'd0;
        tick();
        seed_ld = 1'b0;
        rel     = ecount;
        ticks(66);
        chk("reseed_grant_edge", 64'(last_gcyc - rel), 64'd65);
        chk("reseed_word", last_rnd, first_word);
`endif

        // Randomized traffic with occasional resets and reseeds
        req  = '0;
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            nRST = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 7) == 0)
                req = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
`ifdef RNG_RESEED_EN
            seed_ld = ($urandom_range(0, 199) == 0);
            seed_in = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
`endif
            tick();
        end

        nRST    = 1'b1;
        req     = '0;
        seed_ld = 1'b0;
        ticks(3);
        chk("queue_drained", 64'(sbq.size()), 64'd0);
        done = 1'b1;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
